addr_translation_table: RTL and testbench

//  Literal-to-clause-storage address translation table for the WalkSAT/probSAT FPGA core.
//  - Maps a literal index to a base clause-memory address and a clause-slot mask.
//  - Literal index = {variable number, negation bit}: even entry = positive literal, odd = negated.
//  - Read-only at run time; contents are (re)initialised by reset.
//  - Sits between the variable-select logic and the clause-list memory reader.

---
 rtl/sat_pkg.sv | 26 ++
 rtl/addr_translation_table.sv | 59 +++++
 tb/tb_addr_translation_table.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/sat_pkg.sv
// Shared WalkSAT/probSAT core constants and the literal index format.
// A literal index is the variable number with the negation bit appended as its LSB.
package sat_pkg;

   localparam int MAX_CLAUSES_PER_VARIABLE = 20;
   localparam int LITERAL_ADDRESS_WIDTH    = 11;
   localparam int Nv                       = 32;
   localparam int NvLog2                   = 5;
   localparam int AT_SIZE                  = 2 * Nv;

   typedef struct packed {
      logic [LITERAL_ADDRESS_WIDTH-1:0] var_num;
      logic                             neg;
   } literal_index_t;

   function automatic literal_index_t literal_to_index(
      input logic [LITERAL_ADDRESS_WIDTH-1:0] var_num,
      input logic                             neg
   );
      literal_index_t idx;
      idx.var_num = var_num;
      idx.neg     = neg;
      return idx;
   endfunction

endpackage

// File: rtl/addr_translation_table.sv
// Literal-to-clause-storage translation table: registered lookup of base address and slot mask.
// Contents are re-initialised by reset; out-of-range literals read back as zero.
module addr_translation_table
   import sat_pkg::*;
(
   input  logic                                clk,
   input  logic                                reset,
   input  logic [LITERAL_ADDRESS_WIDTH:0]      index_i,
   output logic [LITERAL_ADDRESS_WIDTH-1:0]    address_o,
   output logic [MAX_CLAUSES_PER_VARIABLE-1:0] mask_o
);

   logic [LITERAL_ADDRESS_WIDTH-1:0]    internal_address_field [AT_SIZE];
   logic [MAX_CLAUSES_PER_VARIABLE-1:0] internal_mask_field    [AT_SIZE];

   literal_index_t                      lit;
   logic                                in_range;
   logic [NvLog2:0]                     entry;
   logic [LITERAL_ADDRESS_WIDTH-1:0]    address_d, address_q;
   logic [MAX_CLAUSES_PER_VARIABLE-1:0] mask_d, mask_q;

   assign lit = index_i;

   // var_num < Nv is the same test as index_i < AT_SIZE, covering every high bit.
   always_comb begin
      in_range  = (lit.var_num < LITERAL_ADDRESS_WIDTH'(Nv));
      entry     = {lit.var_num[NvLog2-1:0], lit.neg};
      address_d = '0;
      mask_d    = '0;
      if (in_range) begin
         address_d = internal_address_field[entry];
         mask_d    = internal_mask_field[entry];
      end
   end

   // Table only changes on reset; between resets it holds whatever was loaded into it.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < AT_SIZE; i++) begin
            internal_address_field[i] <= LITERAL_ADDRESS_WIDTH'(i);
            internal_mask_field[i]    <= {MAX_CLAUSES_PER_VARIABLE{i[0]}};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         address_q <= '0;
         mask_q    <= '0;
      end else begin
         address_q <= address_d;
         mask_q    <= mask_d;
      end
   end

   assign address_o = address_q;
   assign mask_o    = mask_q;

endmodule

// File: tb/tb_addr_translation_table.sv
// Directed bench for addr_translation_table: a table model checked every cycle,
// plus hand-computed literal expectations for the documented scenarios.
module tb_addr_translation_table;
   import sat_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [11:0] index_i;
   logic [10:0] address_o;
   logic [19:0] mask_o;

   int n_checks = 0;
   int n_fail   = 0;

   // Model state: the table contents the outputs must come from.
   logic [10:0] m_addr [64];
   logic [19:0] m_mask [64];
   logic [10:0] exp_addr;
   logic [19:0] exp_mask;
   bit          model_valid = 1'b0;

   addr_translation_table dut (
      .clk       (clk),
      .reset     (reset),
      .index_i   (index_i),
      .address_o (address_o),
      .mask_o    (mask_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < 64; k++) begin
            m_addr[k] = 11'(k);
            m_mask[k] = (k % 2 == 1) ? 20'hFFFFF : 20'h00000;
         end
         exp_addr = 11'd0;
         exp_mask = 20'd0;
      end else if (index_i < 12'd64) begin
         exp_addr = m_addr[index_i];
         exp_mask = m_mask[index_i];
      end else begin
         exp_addr = 11'd0;
         exp_mask = 20'd0;
      end
      model_valid = 1'b1;
   end

   always @(negedge clk) begin
      if (model_valid) begin
         n_checks++;
         if (address_o !== exp_addr || mask_o !== exp_mask) begin
            n_fail++;
            $display("FAIL model_cmp t=%0t idx=%0d: got addr=%0d mask=%05h, required addr=%0d mask=%05h",
                     $time, index_i, address_o, mask_o, exp_addr, exp_mask);
         end
      end
   end

   task automatic cycle(input logic r, input logic [11:0] idx);
      reset   = r;
      index_i = idx;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [10:0] ea, input logic [19:0] em);
      n_checks++;
      if (address_o !== ea || mask_o !== em) begin
         n_fail++;
         $display("FAIL %s: got addr=%0d mask=%05h, required addr=%0d mask=%05h",
                  name, address_o, mask_o, ea, em);
      end
   endtask

   initial begin
      literal_index_t li;
      reset   = 1'b1;
      index_i = '0;

      // Reset
      cycle(1'b1, 12'd0);
      chk("reset_during", 11'd0, 20'h00000);
      cycle(1'b0, 12'd0);
      chk("reset_after", 11'd0, 20'h00000);

      // Sweep all literals
      for (int j = 0; j < 64; j++) begin
         cycle(1'b0, 12'(j));
         if (j == 5)  chk("sweep_5", 11'd5, 20'hFFFFF);
         if (j == 10) chk("sweep_10", 11'd10, 20'h00000);
      end
      chk("sweep_63", 11'd63, 20'hFFFFF);

      // Back-to-back
      cycle(1'b0, 12'd1); chk("b2b_1", 11'd1, 20'hFFFFF);
      cycle(1'b0, 12'd2); chk("b2b_2", 11'd2, 20'h00000);
      cycle(1'b0, 12'd3); chk("b2b_3", 11'd3, 20'hFFFFF);

      // Backdoor write then reset discards it
      dut.internal_mask_field[2] = 20'hABCDE;
      m_mask[2] = 20'hABCDE;
      cycle(1'b0, 12'd2); chk("backdoor_read", 11'd2, 20'hABCDE);
      cycle(1'b1, 12'd2); chk("backdoor_reset", 11'd0, 20'h00000);
      cycle(1'b0, 12'd2); chk("backdoor_restored", 11'd2, 20'h00000);

      // Out of range
      cycle(1'b0, 12'd64);    chk("oor_64", 11'd0, 20'h00000);
      cycle(1'b0, 12'hFFF);   chk("oor_fff", 11'd0, 20'h00000);
      cycle(1'b0, 12'h801);   chk("oor_801", 11'd0, 20'h00000);
      cycle(1'b0, 12'd63);    chk("after_oor_63", 11'd63, 20'hFFFFF);

      // Helper-built literal: var 9 negated = index 19
      li = literal_to_index(11'd9, 1'b1);
      cycle(1'b0, 12'(li));   chk("helper_var9_neg", 11'd19, 20'hFFFFF);

      // Reset mid-stream restores a backdoor-modified address
      dut.internal_address_field[7] = 11'h155;
      m_addr[7] = 11'h155;
      cycle(1'b0, 12'd7); chk("mid_backdoor", 11'h155, 20'hFFFFF);
      cycle(1'b1, 12'd7); chk("mid_reset", 11'd0, 20'h00000);
      cycle(1'b0, 12'd7); chk("mid_restored", 11'd7, 20'hFFFFF);

      // Mixed traffic with backdoor writes and occasional reset, model-checked
      for (int n = 0; n < 300; n++) begin
         int unsigned e;
         e = $urandom_range(63);
         if (n % 37 == 5) begin
            logic [19:0] v;
            v = 20'($urandom);
            dut.internal_mask_field[e] = v;
            m_mask[e] = v;
         end
         if (n % 41 == 11) begin
            logic [10:0] a;
            a = 11'($urandom);
            dut.internal_address_field[e] = a;
            m_addr[e] = a;
         end
         if ($urandom_range(7) == 0)
            cycle(1'b0, 12'($urandom_range(4095)));
         else
            cycle((n % 97 == 50), 12'($urandom_range(63)));
      end

      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
